i2c_master_core: RTL and testbench
==================================

// Module: i2c_master_core
// PURPOSE
//  Single-byte I2C master (7-bit addressing, standard mode). On request, it runs one bus transaction:
//  START, address+R/W, ACK, one data byte (write or read), ACK/NACK, STOP.
//  It sits between the host register logic and the board SCL/SDA pads. SDA is open-drain.
//  SCL is push-pull; clock stretching is not supported.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency
//  SCL_HZ   100_000      SCL frequency; QTR = CLK_HZ/(4*SCL_HZ) = 250 clocks per quarter bit
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  reset: synchronous and active-high
//  tx_ready_i  in   1  request write transaction (rising edge)
//  rx_ready_i  in   1  request read transaction (rising edge)
//  addr_i      in   7  slave address, latched on accept
//  data_i      in   8  write byte, latched on accept
//  data_o      out  8  last byte read; held until next read completes
//  busy_o      out  1  high from accept until end of bus-free time
//  done_o      out  1  1-cycle pulse when transaction ends
//  ack_err_o   out  1  last transaction saw a NACK; cleared on next accept
//  scl_o       out  1  SCL drive
//  sda_oe_o    out  1  1 = pull SDA low, 0 = release
//  sda_i       in   1  SDA pad input, synchronised internally by 2 FFs
// BEHAVIOUR
//  Reset values: scl_o=1, sda_oe_o=0, busy_o=0, done_o=0, ack_err_o=0, data_o=0.
//    Reset clears the FSM, counters and edge registers.
//  Reset mid-transfer: next cycle SCL=1 and SDA is released. No STOP is generated.
//  Quarter tick: the counter wraps every QTR clocks. Each bit slot is 4 quarters:
//    Q0: SCL low, drive/release SDA. Q1: SCL rise. Q2: SCL high, sample sda_i. Q3: SCL fall.
//  Accept: only in IDLE, on a 0->1 edge of tx_ready_i or rx_ready_i (registered previous value).
//    Write wins if both edges occur in the same cycle.
//    Edges seen while busy are dropped. A level held high does not retrigger.
//    Accept latches addr_i, data_i and the R/W bit (read=1), and clears ack_err_o.
//  FSM states: IDLE -> START -> ADDR(8 bits, MSB first) -> ADDR_ACK
//    -> WRITE(8 bits) -> WR_ACK -> STOP, or
//    -> READ(8 bits) -> RD_ACK(master NACK, SDA released) -> STOP.
//    STOP -> BUSFREE(4 quarters) -> IDLE.
//  START: Q0-Q1 SCL=1 with SDA released; Q2 SDA low with SCL high; Q3 SCL low.
//  STOP: Q0 SCL low with SDA low; Q1 SCL high; Q2 SDA released with SCL high; Q3 hold.
//  ACK slots: SDA released; sample at Q2. sda_i=1 means NACK: set ack_err_o and go to STOP.
//    An address NACK skips the data phase.
//  READ: SDA released; sample at Q2 into a shift register, MSB first.
//    data_o updates at the end of RD_ACK only.
//  SDA changes only while SCL is low, except START/STOP edges.
//  Duration: 20 bit slots (80*QTR = 20000 clocks at defaults) from accept to done_o, +-2 clocks.
//    Address NACK: 11 slots.
//  done_o pulses on entry to BUSFREE. busy_o drops on return to IDLE.
// TESTING
//  1 Reset held 5 cycles -> scl_o=1, sda_oe_o=0, busy_o=0, data_o=0x00.
//  2 addr_i=0x50, data_i=0x55, tx_ready_i 0->1, slave ACKs
//    -> SDA bits 1010000_0, ack, 01010101, ack, STOP; done_o ~20000 clocks later; ack_err_o=0.
//  3 Same write with slave never pulling SDA low -> address NACK, STOP after 11 slots, ack_err_o=1.
//  4 rx_ready_i 0->1, slave drives 0xA5 -> data_o=0xA5 after done_o; master NACKs the byte.
//  5 tx_ready_i pulses while busy_o=1, and tx_ready_i held high for 1000 cycles
//    -> exactly one transaction.
//  6 rst asserted mid-ADDR -> next cycle scl_o=1, sda_oe_o=0, busy_o=0; new request accepted after release.

Source files
------------

// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, 7-bit address + R/W, ACK, one data byte
// (write or read), ACK/NACK, STOP, then a bus-free interval.
// SDA is open-drain (sda_oe_o=1 pulls low); SCL is push-pull, no stretching.
module i2c_master_core #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned SCL_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready_i,
  input  logic       rx_ready_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       scl_o,
  output logic       sda_oe_o,
  input  logic       sda_i
);

  localparam int unsigned QTR = CLK_HZ / (4 * SCL_HZ);
  localparam int unsigned CW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK,
    S_READ, S_RD_ACK, S_STOP, S_BUSFREE
  } state_t;

  state_t        state;
  logic [CW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bitcnt;
  logic          tick;
  logic          tx_prev, rx_prev;
  logic          tx_edge, rx_edge;
  logic [1:0]    sda_sync;
  logic          sda_s;
  logic [7:0]    addr_byte;   // {addr, R/W}; bit 0 = 1 for read
  logic [7:0]    data_byte;
  logic [7:0]    rx_shift;
  logic          scl_nx, oe_nx;

  assign tick    = (qcnt == CW'(QTR - 1));
  assign tx_edge = tx_ready_i & ~tx_prev;
  assign rx_edge = rx_ready_i & ~rx_prev;
  assign sda_s   = sda_sync[1];

  // Two-flop synchroniser for the SDA pad input.
  always_ff @(posedge clk) begin
    if (rst) sda_sync <= 2'b11;
    else     sda_sync <= {sda_sync[0], sda_i};
  end

  // Bus pin levels implied by the current state and quarter; registered below.
  always_comb begin
    scl_nx = 1'b1;
    oe_nx  = 1'b0;
    case (state)
      S_START: begin
        scl_nx = (q != 2'd3);
        oe_nx  = q[1];
      end
      S_ADDR: begin
        scl_nx = (q == 2'd1) || (q == 2'd2);
        oe_nx  = ~addr_byte[~bitcnt];
      end
      S_WRITE: begin
        scl_nx = (q == 2'd1) || (q == 2'd2);
        oe_nx  = ~data_byte[~bitcnt];
      end
      S_ADDR_ACK, S_WR_ACK, S_READ, S_RD_ACK: begin
        scl_nx = (q == 2'd1) || (q == 2'd2);
        oe_nx  = 1'b0;
      end
      S_STOP: begin
        scl_nx = (q != 2'd0);
        oe_nx  = ~q[1];
      end
      default: begin
        scl_nx = 1'b1;
        oe_nx  = 1'b0;
      end
    endcase
  end

  // Transaction FSM with quarter-bit timebase and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      q         <= '0;
      bitcnt    <= '0;
      tx_prev   <= 1'b0;
      rx_prev   <= 1'b0;
      addr_byte <= '0;
      data_byte <= '0;
      rx_shift  <= '0;
      data_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ack_err_o <= 1'b0;
      scl_o     <= 1'b1;
      sda_oe_o  <= 1'b0;
    end else begin
      tx_prev  <= tx_ready_i;
      rx_prev  <= rx_ready_i;
      done_o   <= 1'b0;
      scl_o    <= scl_nx;
      sda_oe_o <= oe_nx;

      if (state == S_IDLE) begin
        qcnt <= '0;
        q    <= '0;
        if (tx_edge || rx_edge) begin
          addr_byte <= {addr_i, ~tx_edge};
          data_byte <= data_i;
          ack_err_o <= 1'b0;
          busy_o    <= 1'b1;
          bitcnt    <= '0;
          state     <= S_START;
        end
      end else if (!tick) begin
        qcnt <= qcnt + 1'b1;
      end else begin
        qcnt <= '0;
        q    <= q + 2'd1;
        if (q == 2'd2) begin
          case (state)
            S_ADDR_ACK, S_WR_ACK: if (sda_s) ack_err_o <= 1'b1;
            S_READ:               rx_shift <= {rx_shift[6:0], sda_s};
            default: ;
          endcase
        end
        if (q == 2'd3) begin
          case (state)
            S_START: begin
              bitcnt <= '0;
              state  <= S_ADDR;
            end
            S_ADDR: begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
              bitcnt <= '0;
              if (ack_err_o)         state <= S_STOP;
              else if (addr_byte[0]) state <= S_READ;
              else                   state <= S_WRITE;
            end
            S_WRITE: begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= S_WR_ACK;
            end
            S_READ: begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= S_RD_ACK;
            end
            S_WR_ACK: state <= S_STOP;
            S_RD_ACK: begin
              data_o <= rx_shift;
              state  <= S_STOP;
            end
            S_STOP: begin
              done_o <= 1'b1;
              state  <= S_BUSFREE;
            end
            S_BUSFREE: begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with a small open-drain slave model.
module tb_i2c_master_core;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned SCL_HZ = 10_000;
  localparam int unsigned QTR    = 25;
  localparam int unsigned T_FULL = 80 * QTR + 1;  // negedges from request to done seen
  localparam int unsigned T_NACK = 44 * QTR + 1;
  localparam int unsigned T_FREE = 4 * QTR;

  logic       clk = 1'b0;
  logic       rst, tx_ready_i, rx_ready_i;
  logic [6:0] addr_i;
  logic [7:0] data_i, data_o;
  logic       busy_o, done_o, ack_err_o, scl_o, sda_oe_o, sda_i;
  logic       sda_line;
  logic       slave_pull = 1'b0;

  int checks = 0;
  int errors = 0;

  // Slave model state
  int          k = 99;
  logic        ack_en = 1'b1;
  logic        slave_rd = 1'b0;
  logic [7:0]  rd_byte = 8'hA5;
  logic [1:18] bits = '0;
  int          starts = 0;
  int          stops = 0;

  i2c_master_core #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ)) dut (
    .clk(clk), .rst(rst), .tx_ready_i(tx_ready_i), .rx_ready_i(rx_ready_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .busy_o(busy_o),
    .done_o(done_o), .ack_err_o(ack_err_o), .scl_o(scl_o),
    .sda_oe_o(sda_oe_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  assign sda_line = ~(sda_oe_o | slave_pull);
  assign sda_i    = sda_line;

  always @(negedge sda_line) if (scl_o === 1'b1) begin k = 0; starts++; end
  always @(posedge sda_line) if (scl_o === 1'b1) stops++;

  // Slave drives SDA only while SCL is low: ACK on bit 9 / 18, read data on 10..17.
  always @(negedge scl_o) begin
    k++;
    slave_pull = 1'b0;
    if (k == 9 && ack_en) slave_pull = 1'b1;
    if (slave_rd && k >= 10 && k <= 17) slave_pull = ~rd_byte[17 - k];
    if (!slave_rd && k == 18 && ack_en) slave_pull = 1'b1;
  end

  always @(posedge scl_o) if (k >= 1 && k <= 18) bits[k] = sda_line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Issue one request and wait (bounded) for done_o and then busy_o low.
  task automatic run(input bit rd, input string tag, output int n, output int m);
    @(negedge clk);
    if (rd) rx_ready_i = 1'b1; else tx_ready_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (done_o !== 1'b1 && n < 5000);
    chk({tag, "_busy_at_done"}, busy_o, 1'b1);
    tx_ready_i = 1'b0;
    rx_ready_i = 1'b0;
    m = 0;
    do begin @(negedge clk); m++; end while (busy_o !== 1'b0 && m < 1000);
    chk_rng({tag, "_busfree"}, m, T_FREE - 2, T_FREE + 2);
  endtask

  initial begin
    int n, m, s0, p0;
    rst = 1'b1; tx_ready_i = 1'b0; rx_ready_i = 1'b0;
    addr_i = '0; data_i = '0;

    // 1: reset values
    repeat (5) @(negedge clk);
    chk("rst_scl", scl_o, 1'b1);
    chk("rst_oe", sda_oe_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", ack_err_o, 1'b0);
    chk("rst_data", data_o, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 2: write 0x55 to 0x50, slave ACKs
    addr_i = 7'h50; data_i = 8'h55; ack_en = 1'b1; slave_rd = 1'b0;
    s0 = starts; p0 = stops;
    run(1'b0, "wr", n, m);
    chk_rng("wr_dur", n, T_FULL - 2, T_FULL + 2);
    chk("wr_addr", bits[1:8], 8'hA0);
    chk("wr_ack1", bits[9], 1'b0);
    chk("wr_data", bits[10:17], 8'h55);
    chk("wr_ack2", bits[18], 1'b0);
    chk("wr_err", ack_err_o, 1'b0);
    chk("wr_starts", starts - s0, 1);
    chk("wr_stops", stops - p0, 1);
    chk("wr_idle_scl", scl_o, 1'b1);
    chk("wr_idle_oe", sda_oe_o, 1'b0);

    // 3: address NACK
    ack_en = 1'b0; p0 = stops;
    run(1'b0, "nack", n, m);
    chk_rng("nack_dur", n, T_NACK - 2, T_NACK + 2);
    chk("nack_addr", bits[1:8], 8'hA0);
    chk("nack_bit", bits[9], 1'b1);
    chk("nack_err", ack_err_o, 1'b1);
    chk("nack_stop", stops - p0, 1);

    // 4: read, slave returns 0xA5, master NACKs
    ack_en = 1'b1; slave_rd = 1'b1; rd_byte = 8'hA5;
    run(1'b1, "rd", n, m);
    chk_rng("rd_dur", n, T_FULL - 2, T_FULL + 2);
    chk("rd_addr", bits[1:8], 8'hA1);
    chk("rd_bus_byte", bits[10:17], 8'hA5);
    chk("rd_master_nack", bits[18], 1'b1);
    chk("rd_data", data_o, 8'hA5);
    chk("rd_err", ack_err_o, 1'b0);

    // 5: re-pulse while busy and level held high -> one transaction
    slave_rd = 1'b0; addr_i = 7'h3C; data_i = 8'hC3;
    s0 = starts;
    @(negedge clk); tx_ready_i = 1'b1;
    repeat (300) @(negedge clk);
    tx_ready_i = 1'b0;
    @(negedge clk); tx_ready_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (done_o !== 1'b1 && n < 5000);
    chk_rng("hold_dur", n, T_FULL - 302, T_FULL - 298);
    m = 0;
    do begin @(negedge clk); m++; end while (busy_o !== 1'b0 && m < 1000);
    repeat (200) @(negedge clk);
    chk("hold_busy", busy_o, 1'b0);
    chk("hold_starts", starts - s0, 1);
    chk("hold_addr", bits[1:8], 8'h78);
    chk("hold_data", bits[10:17], 8'hC3);
    chk("rd_data_held", data_o, 8'hA5);
    tx_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    // 6: reset during ADDR (address bit 4 = 0, SCL low), then new request
    addr_i = 7'h50; data_i = 8'h55;
    @(negedge clk); tx_ready_i = 1'b1;
    repeat (511) @(negedge clk);
    chk("mid_scl", scl_o, 1'b0);
    chk("mid_oe", sda_oe_o, 1'b1);
    chk("mid_busy", busy_o, 1'b1);
    rst = 1'b1; tx_ready_i = 1'b0;
    @(negedge clk);
    chk("mrst_scl", scl_o, 1'b1);
    chk("mrst_oe", sda_oe_o, 1'b0);
    chk("mrst_busy", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, "post", n, m);
    chk_rng("post_dur", n, T_FULL - 2, T_FULL + 2);
    chk("post_addr", bits[1:8], 8'hA0);
    chk("post_data", bits[10:17], 8'h55);
    chk("post_err", ack_err_o, 1'b0);
    chk("post_rd_data", data_o, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
